// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scan_mux channel multiplexer.
//   - DEF_WIDTH / DEF_CHANNELS : default channel width and channel count
//   - MAX_CHANNELS             : widest channel vector the helpers can handle
//   - onehot(idx, n)           : one-hot vector with bit idx set (zero if idx >= n)
//   - next_unmasked(idx, mask, n) : first channel after idx, searching upward
//                                with wrap, whose mask bit is set; returns idx
//                                itself when it is the only one set or when
//                                no bit is set at all
// -----------------------------------------------------------------------------
package scan_mux_pkg;

    localparam int DEF_WIDTH    = 7;
    localparam int DEF_CHANNELS = 4;
    localparam int MAX_CHANNELS = 64;

    function automatic logic [MAX_CHANNELS-1:0] onehot(
        input int unsigned idx,
        input int unsigned n
    );
        logic [MAX_CHANNELS-1:0] v;
        v = '0;
        if (idx < n) begin
            v = MAX_CHANNELS'(1) << idx;
        end
        return v;
    endfunction

    // The candidate at offset k == n is idx itself, so a lone unmasked
    // current channel, or an all-zero mask, leaves the index where it is.
    function automatic int unsigned next_unmasked(
        input int unsigned             idx,
        input logic [MAX_CHANNELS-1:0] mask,
        input int unsigned             n
    );
        int unsigned result;
        int unsigned cand;
        logic        found;
        result = idx;
        found  = 1'b0;
        for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
            if (k <= n) begin
                cand = (idx + k) % n;
                if (!found && mask[cand[5:0]]) begin
                    result = cand;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_mux_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Dwell counter for auto-scan mode. Counts 0..SCAN_DIV-1 and wraps.
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   i_clear in   holds the count at 0 (manual mode)
//   o_cnt   out  current dwell count
//   o_tc    out  terminal count: high while o_cnt == SCAN_DIV-1 and not cleared
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter  int SCAN_DIV = 50000,
    localparam int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc  = !i_clear && (r_cnt == LAST_CNT);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// Registered N-channel, W-bit multiplexer with manual select and an auto-scan
// mode that rotates through unmasked channels, dwelling SCAN_DIV cycles each.
// Used to drive time-multiplexed displays and debug channel viewers.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (synchronous release expected)
//   in_bus   in   CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   sel      in   manual channel select
//   auto_en  in   1 = auto-scan, 0 = manual
//   ch_mask  in   auto mode: 1 = channel takes part in the rotation
//   out      out  selected channel data (registered)
//   out_sel  out  index of the channel currently on out
//   ch_en    out  one-hot enable of the active channel (registered)
//   strobe   out  one-cycle pulse on each auto-mode channel advance
//
// Build option: define SCAN_MUX_BLANK_EN to blank out/ch_en during the first
// BLANK_CYCLES cycles of every auto-mode dwell (anti-ghosting). Without it no
// blanking logic is built and BLANK_CYCLES has no effect.
// -----------------------------------------------------------------------------
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH        = DEF_WIDTH,
    parameter  int CHANNELS     = DEF_CHANNELS,
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int SEL_W        = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto_en,
    input  logic [CHANNELS-1:0]       ch_mask,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_sel,
    output logic [CHANNELS-1:0]       ch_en,
    output logic                      strobe
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [SEL_W-1:0]    r_idx;
    logic [WIDTH-1:0]    r_out;
    logic [SEL_W-1:0]    r_out_sel;
    logic [CHANNELS-1:0] r_ch_en;
    logic                r_strobe;

    logic [SEL_W-1:0]    w_idx_next;
    logic [WIDTH-1:0]    w_out_next;
    logic [CHANNELS-1:0] w_ch_en_next;
    logic                w_in_range;
    logic                w_tc;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_blank;
    logic [WIDTH-1:0]    w_ch [CHANNELS];

    // Dwell counter is held clear in manual mode so auto entry always
    // starts a fresh, full-length dwell.
    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (!auto_en),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_ch[gi] = in_bus[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        w_idx_next = r_idx;
        if (!auto_en) begin
            w_idx_next = sel;
        end else if (w_tc) begin
            w_idx_next = SEL_W'(next_unmasked(32'(r_idx), MAX_CHANNELS'(ch_mask), CHANNELS));
        end
    end

    // Only reachable with a manual sel beyond the last channel when
    // CHANNELS is not a power of two.
    assign w_in_range = (32'(w_idx_next) < 32'(CHANNELS));

`ifdef SCAN_MUX_BLANK_EN
    // Blank while the count that will be current on the next cycle lies in
    // the blanking window, so the blank lines up with the dwell as seen on
    // out. On terminal count the next count is 0.
    assign w_blank = auto_en &&
                     (w_tc ? (BLANK_CYCLES > 0)
                           : ((32'(w_cnt) + 32'd1) < 32'(BLANK_CYCLES)));
`else
    localparam int blank_cycles_unused = BLANK_CYCLES;
    logic [CNT_W-1:0] w_cnt_unused;
    assign w_cnt_unused = w_cnt;
    assign w_blank      = 1'b0;
`endif

    always_comb begin
        w_out_next   = '0;
        w_ch_en_next = '0;
        if (w_in_range) begin
            w_out_next   = w_ch[w_idx_next];
            w_ch_en_next = CHANNELS'(onehot(32'(w_idx_next), CHANNELS));
            // Mask is applied every cycle, so masking the current channel
            // darkens it immediately while the index itself only moves at
            // the next advance.
            if (auto_en) begin
                w_ch_en_next = w_ch_en_next & ch_mask;
            end
        end
        if (w_blank) begin
            w_out_next   = '0;
            w_ch_en_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_out     <= '0;
            r_out_sel <= '0;
            r_ch_en   <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_idx     <= w_idx_next;
            r_out     <= w_out_next;
            r_out_sel <= w_idx_next;
            r_ch_en   <= w_ch_en_next;
            r_strobe  <= w_tc;
        end
    end

    assign out     = r_out;
    assign out_sel = r_out_sel;
    assign ch_en   = r_ch_en;
    assign strobe  = r_strobe;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
// Self-checking bench for scan_mux (WIDTH=7, CHANNELS=4, SCAN_DIV=4,
// BLANK_CYCLES=2). Directed manual-mode vector table, hand-written auto-mode
// sequences, then randomized stimulus against a behavioural model.
// -----------------------------------------------------------------------------
module tb_scan_mux;

    localparam int W  = 7;
    localparam int CH = 4;
    localparam int SD = 4;
    localparam int BL = 2;

`ifdef SCAN_MUX_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH*W-1:0] in_bus;
    logic [1:0]    sel;
    logic          auto_en;
    logic [CH-1:0] ch_mask;
    logic [W-1:0]  out;
    logic [1:0]    out_sel;
    logic [CH-1:0] ch_en;
    logic          strobe;

    scan_mux #(
        .WIDTH        (W),
        .CHANNELS     (CH),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_bus  (in_bus),
        .sel     (sel),
        .auto_en (auto_en),
        .ch_mask (ch_mask),
        .out     (out),
        .out_sel (out_sel),
        .ch_en   (ch_en),
        .strobe  (strobe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: which channel is shown and how many cycles of its
    // dwell have elapsed (position 0 is the first cycle the channel is shown).
    int         m_idx;
    int         m_pos;
    logic [6:0] e_out;
    logic [1:0] e_sel;
    logic [3:0] e_en;
    logic       e_strobe;

    function automatic logic [6:0] chan(input logic [CH*W-1:0] bus, input int k);
        return 7'(bus >> (k * W));
    endfunction

    function automatic int next_ch(input int cur, input logic [CH-1:0] m);
        for (int k = 1; k <= CH; k++) begin
            if (m[(cur + k) % CH]) return (cur + k) % CH;
        end
        return cur;
    endfunction

    task automatic model_step();
        if (!auto_en) begin
            m_idx    = int'(sel);
            m_pos    = 0;
            e_strobe = 1'b0;
        end else begin
            e_strobe = (m_pos == SD - 1);
            if (e_strobe) begin
                m_pos = 0;
                m_idx = next_ch(m_idx, ch_mask);
            end else begin
                m_pos = m_pos + 1;
            end
        end
        e_sel = 2'(m_idx);
        e_out = chan(in_bus, m_idx);
        e_en  = 4'(1 << m_idx);
        if (auto_en && !ch_mask[m_idx]) e_en = 4'b0;
        if (BLANK_ON && auto_en && m_pos < BL) begin
            e_out = 7'b0;
            e_en  = 4'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},     32'(out),     32'(e_out));
        chk({tag, ".out_sel"}, 32'(out_sel), 32'(e_sel));
        chk({tag, ".ch_en"},   32'(ch_en),   32'(e_en));
        chk({tag, ".strobe"},  32'(strobe),  32'(e_strobe));
    endtask

    // Advance one clock; model sees the inputs that were present at the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] mask;
        logic [6:0] c0, c1, c2, c3;
        logic [6:0] eout;
        logic [1:0] esel;
        logic [3:0] een;
    } vec_t;

    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int q_sel [$];

        rst_n   = 1'b0;
        auto_en = 1'b0;
        sel     = 2'd0;
        ch_mask = 4'hF;
        in_bus  = '0;
        m_idx   = 0;
        m_pos   = 0;

        vt[0] = '{2'd2, 4'hF, 7'h11, 7'h22, 7'h5A, 7'h33, 7'h5A, 2'd2, 4'b0100};
        vt[1] = '{2'd1, 4'hF, 7'h01, 7'h02, 7'h03, 7'h04, 7'h02, 2'd1, 4'b0010};
        vt[2] = '{2'd3, 4'h0, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0D, 2'd3, 4'b1000};
        vt[3] = '{2'd2, 4'h5, 7'h7F, 7'h00, 7'h00, 7'h7F, 7'h00, 2'd2, 4'b0100};
        vt[4] = '{2'd1, 4'h0, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h7F, 2'd1, 4'b0010};
        vt[5] = '{2'd0, 4'hA, 7'h6B, 7'h11, 7'h22, 7'h33, 7'h6B, 2'd0, 4'b0001};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.out",     32'(out),     32'd0);
        chk("reset.out_sel", 32'(out_sel), 32'd0);
        chk("reset.ch_en",   32'(ch_en),   32'd0);
        chk("reset.strobe",  32'(strobe),  32'd0);
        rst_n = 1'b1;

        // Manual-mode vector table: one cycle latency, mask ignored.
        for (int i = 0; i < 6; i++) begin
            sel     = vt[i].sel;
            ch_mask = vt[i].mask;
            in_bus  = {vt[i].c3, vt[i].c2, vt[i].c1, vt[i].c0};
            cycle();
            $display("vec %0d sel=%0d out=%h out_sel=%0d ch_en=%b strobe=%b",
                     i, vt[i].sel, out, out_sel, ch_en, strobe);
            chk("vec.out",     32'(out),     32'(vt[i].eout));
            chk("vec.out_sel", 32'(out_sel), 32'(vt[i].esel));
            chk("vec.ch_en",   32'(ch_en),   32'(vt[i].een));
            chk("vec.strobe",  32'(strobe),  32'd0);
        end

        // Auto scan, all channels: 0,0,0,1,1,1,1,2,... strobe on each change.
        auto_en = 1'b1;
        ch_mask = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            in_bus = (CH*W)'({$urandom, $urandom});
            cycle();
            $display("scan k=%0d out_sel=%0d strobe=%b ch_en=%b out=%h", k, out_sel, strobe, ch_en, out);
            chk("scan.sel",    32'(out_sel), 32'((k / 4) % 4));
            chk("scan.strobe", 32'(strobe),  32'(k % 4 == 0));
            chk("scan.blank",  32'(ch_en == 4'b0), 32'(BLANK_ON && (k % 4 <= 1)));
            chk_model("scan");
        end

        // Mask 1010 from channel 0: rotation 1,3,1,3.
        ch_mask = 4'b1010;
        for (int k = 1; k <= 16; k++) begin
            in_bus = (CH*W)'({$urandom, $urandom});
            cycle();
            if (strobe) q_sel.push_back(int'(out_sel));
            chk_model("mask");
        end
        $display("mask rotation count=%0d", q_sel.size());
        chk("mask.count", 32'(q_sel.size()), 32'd4);
        if (q_sel.size() == 4) begin
            chk("mask.rot0", 32'(q_sel[0]), 32'd1);
            chk("mask.rot1", 32'(q_sel[1]), 32'd3);
            chk("mask.rot2", 32'(q_sel[2]), 32'd1);
            chk("mask.rot3", 32'(q_sel[3]), 32'd3);
        end

        // All channels masked mid-dwell: dark next cycle, index frozen.
        cycle();
        chk_model("premask");
        ch_mask = 4'b0000;
        cycle();
        $display("allmasked ch_en=%b out_sel=%0d", ch_en, out_sel);
        chk("allmask.dark", 32'(ch_en), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk_model("allmask");
        end
        chk("allmask.frozen", 32'(out_sel), 32'd3);

        // Auto -> manual (sel=3) mid-dwell, then back to auto.
        ch_mask = 4'hF;
        cycle();
        chk_model("pre_manual");
        auto_en = 1'b0;
        sel     = 2'd3;
        cycle();
        $display("to_manual out_sel=%0d", out_sel);
        chk("manual.sel", 32'(out_sel), 32'd3);
        auto_en = 1'b1;
        n = 0;
        do begin
            cycle();
            chk_model("reentry");
            n++;
        end while (!strobe && n < 20);
        $display("reentry advance after %0d cycles to %0d", n, out_sel);
        chk("reentry.delay", 32'(n), 32'(SD));
        chk("reentry.ch",    32'(out_sel), 32'd0);

        // Asynchronous reset mid-dwell, then full dwell from channel 0.
        cycle();
        chk_model("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset out=%h out_sel=%0d ch_en=%b strobe=%b", out, out_sel, ch_en, strobe);
        chk("areset.out",     32'(out),     32'd0);
        chk("areset.out_sel", 32'(out_sel), 32'd0);
        chk("areset.ch_en",   32'(ch_en),   32'd0);
        chk("areset.strobe",  32'(strobe),  32'd0);
        m_idx = 0;
        m_pos = 0;
        cycle();
        rst_n = 1'b1;
        n = 0;
        do begin
            cycle();
            chk_model("post_reset");
            n++;
        end while (!strobe && n < 20);
        $display("post_reset advance after %0d cycles to %0d", n, out_sel);
        chk("postreset.delay", 32'(n), 32'(SD));
        chk("postreset.ch",    32'(out_sel), 32'd1);

        // Randomized stimulus against the model.
        for (int k = 0; k < 400; k++) begin
            in_bus = (CH*W)'({$urandom, $urandom});
            sel    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 7) == 0)  ch_mask = 4'($urandom_range(0, 15));
            cycle();
            $display("rnd %0d auto=%b sel=%0d mask=%b out=%h out_sel=%0d ch_en=%b strobe=%b",
                     k, auto_en, sel, ch_mask, out, out_sel, ch_en, strobe);
            chk_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel, W-bit multiplexer with an auto-scan mode. It generalises the fixed 7-bit, 4-input combinational mux. It drives time-multiplexed outputs such as multi-digit seven-segment displays and debug channel viewers in the vision pipeline. It selects one channel either from an external select (manual) or from an internal dwell counter that rotates through the unmasked channels (auto), and emits a one-hot channel enable aligned with the data.

## Interface
- WIDTH, 7, bits per channel
- CHANNELS, 4, number of input channels (>=2)
- SCAN_DIV, 50000, clock cycles per channel dwell in auto mode (>=2)
- BLANK_CYCLES, 16, blanking cycles at start of each dwell (used only with blanking compiled in; must be < SCAN_DIV)
- SEL_W, $clog2(CHANNELS), select width (derived, not overridden)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_bus  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select
- auto_en  in  1  1 = auto-scan, 0 = manual
- ch_mask  in  CHANNELS  auto mode: 1 = channel participates
- out  out  WIDTH  selected channel data, registered
- out_sel  out  SEL_W  index of channel currently on out
- ch_en  out  CHANNELS  one-hot enable of active channel, registered
- strobe  out  1  one-cycle pulse on each auto-mode channel advance

## Operation
- Internal state: idx (SEL_W), dwell counter cnt (0..SCAN_DIV-1).
- idx_next is combinational. All outputs register from idx_next.
- out <= in_bus slice at idx_next. out_sel <= idx_next.
- Manual mode (auto_en=0): idx_next = sel; cnt held at 0; ch_en <= onehot(sel), mask ignored; strobe = 0.
- Out-of-range sel (sel >= CHANNELS, non-power-of-2 CHANNELS): out = 0, ch_en = 0, out_sel = sel.
- Auto mode: cnt increments each cycle.
- At cnt == SCAN_DIV-1: cnt <= 0, idx_next = first index after idx, searching upward with wrap, whose ch_mask bit is 1; strobe <= 1.
- Otherwise idx_next = idx.
- ch_en <= onehot(idx_next) & ch_mask: a channel masked mid-dwell goes dark on the next cycle.
- A mask change affects rotation only at the next advance.
- All channels masked: idx holds, ch_en = 0, out keeps tracking in_bus at idx, strobe still pulses.
- Only the current channel is unmasked: idx stays put and strobe still pulses.
- Manual to auto: cnt starts at 0, rotation begins from current idx.
- Auto to manual: next cycle follows sel, cnt cleared.
- in_bus changes are reflected on out one cycle later, even mid-dwell.

## Timing
- Reset (async assert, sync release): out=0, out_sel=0, ch_en=0, strobe=0, idx=0, cnt=0.
- First post-reset edge: outputs reflect channel 0 (auto) or sel (manual).
- Latency: sel or in_bus to out/ch_en/out_sel is 1 cycle.
- strobe is coincident with the first cycle of the new channel on out.
- Auto dwell is exactly SCAN_DIV cycles per channel.
- Reset asserted mid-dwell: outputs clear immediately and cnt restarts at 0.

## Configuration
- Macro SCAN_MUX_BLANK_EN.
- Defined: in auto mode, for the first BLANK_CYCLES cycles of each dwell (cnt < BLANK_CYCLES, including the first dwell after reset or mode entry), ch_en=0 and out=0. out_sel and strobe are unaffected. This suppresses display ghosting.
- Undefined: no blanking, BLANK_CYCLES is ignored, and no blanking comparator is synthesised.
- Manual mode never blanks in either build.

## Structure
- Package scan_mux_pkg holds:
  - function onehot(idx, n)
  - function next_unmasked(idx, mask) returning the wrapped search result
  - localparam defaults for WIDTH and CHANNELS.
- Sub-module scan_prescaler contains the SCAN_DIV dwell counter. It has a clear input and exposes terminal-count (tc) and cnt, so the blank comparison can use cnt.
- Top level contains the idx register, output registers and the mux.

## Test plan
- Reset, then manual mode with sel=2 and channel 2 = 7'h5A: 1 cycle later out=7'h5A, ch_en=4'b0100, out_sel=2, strobe=0.
- Auto mode, SCAN_DIV=4, mask=4'b1111: out_sel sequence 0,0,0,0,1,1,1,1,2,..., wraps 3→0. strobe pulses on each change.
- Auto mode, mask=4'b1010: rotation is 1,3,1,3. Setting mask=0 mid-dwell gives ch_en=0 the next cycle and idx frozen.
- Auto mode, SCAN_DIV=8, BLANK_CYCLES=2, with SCAN_MUX_BLANK_EN: out=0 and ch_en=0 for the first 2 cycles of every dwell. Without the macro, no zero cycles appear.
- Switch auto→manual (sel=3) mid-dwell: next cycle out_sel=3. Switch back: the next advance occurs SCAN_DIV cycles later, to channel 0.
- Assert rst_n=0 asynchronously mid-dwell: all outputs are 0 before the next clk edge. After release, the scan restarts from channel 0 with a full dwell.
